// File: rtl/memory_stage_pkg.sv
// Shared definitions for the ME (memory) stage of the pipelined MIPS core.
// Holds the datapath width, the ME-stage FSM state encoding, byte-enable
// constants and the packed payload of the ME pipeline register.
package memory_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [3:0] BE_WORD  = 4'hF;
  localparam logic [3:0] BE_BYTE0 = 4'h1;

  typedef enum logic {
    ME_IDLE = 1'b0,
    ME_WAIT = 1'b1
  } me_state_e;

  // ME pipeline register payload (result + writeback control)
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      wreg;
    logic            reg_write;
    logic            instr_val;
  } me_reg_t;

endpackage

// File: rtl/memory_stage_byte_lane_fmt.sv
// byte_lane_fmt: combinational byte-lane formatting for data memory accesses.
//   byte_sel   : byte offset within the word (address bits [1:0])
//   store_byte : SB access -> single-lane enable, store byte replicated
//   load_byte  : LB access -> select addressed read byte and sign-extend
//   wr_dat     : raw store data from EX
//   rd_dat     : raw read data from memory
//   byte_en_c  : lane enables for the memory port
//   wr_lane_c  : lane-aligned store data
//   rd_fmt_c   : formatted load data
module byte_lane_fmt
  import memory_stage_pkg::*;
(
  input  logic [1:0]      byte_sel,
  input  logic            store_byte,
  input  logic            load_byte,
  input  logic [XLEN-1:0] wr_dat,
  input  logic [XLEN-1:0] rd_dat,
  output logic [3:0]      byte_en_c,
  output logic [XLEN-1:0] wr_lane_c,
  output logic [XLEN-1:0] rd_fmt_c
);

  logic [7:0] rd_byte;

  // Store side: word passes through, byte is replicated on all lanes
  always_comb begin
    byte_en_c = BE_WORD;
    wr_lane_c = wr_dat;
    if (store_byte) begin
      byte_en_c = BE_BYTE0 << byte_sel;
      wr_lane_c = {4{wr_dat[7:0]}};
    end
  end

  // Load side: pick the addressed byte
  always_comb begin
    rd_byte = rd_dat[7:0];
    case (byte_sel)
      2'd0: rd_byte = rd_dat[7:0];
      2'd1: rd_byte = rd_dat[15:8];
      2'd2: rd_byte = rd_dat[23:16];
      2'd3: rd_byte = rd_dat[31:24];
      default: rd_byte = rd_dat[7:0];
    endcase
  end

  assign rd_fmt_c = load_byte ? {{(XLEN-8){rd_byte[7]}}, rd_byte} : rd_dat;

endmodule

// File: rtl/memory_stage.sv
// memory_stage: ME stage of the pipelined MIPS core. Issues loads/stores to
// the data memory over a req/ack port, formats byte data and registers the
// ME result used for bypass and writeback.
//   clk, rst_n          : clock, async active-low reset
//   flush               : turn the instruction entering ME into a bubble
//   *_EX                : registered execute-stage outputs
//   Dm*                 : data memory req/ack port (DmReq/DmWe/DmAddr/DmByteEn/
//                         DmWrDat out, DmAck/DmRdDat in); request outputs are
//                         combinational from EX and the FSM state
//   MemStall_ME         : combinational stall, high while memory has not acked
//   *_ME                : registered ME result and control
//   MemWaitCycles_ME    : saturating count of stall cycles
// Optional: define MEM_ALIGN_CHECK_EN to drop misaligned word accesses into a
// bubble and raise the sticky AlignErr_ME output.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned WAIT_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [XLEN-1:0]       Result_EX,
  input  logic [XLEN-1:0]       WrDat_EX,
  input  logic [4:0]            WriteReg_EX,
  input  logic                  RegWrite_EX,
  input  logic                  MemToReg_EX,
  input  logic                  MemWrite_EX,
  input  logic                  LoadB_EX,
  input  logic                  StoreB_EX,
  input  logic                  InstrVal_EX,
  output logic                  DmReq,
  output logic                  DmWe,
  output logic [XLEN-1:0]       DmAddr,
  output logic [3:0]            DmByteEn,
  output logic [XLEN-1:0]       DmWrDat,
  input  logic                  DmAck,
  input  logic [XLEN-1:0]       DmRdDat,
  output logic                  MemStall_ME,
  output logic [XLEN-1:0]       ResultRdDat_ME,
  output logic [4:0]            WriteReg_ME,
  output logic                  RegWrite_ME,
  output logic                  InstrVal_ME,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                  AlignErr_ME,
`endif
  output logic [WAIT_CNT_W-1:0] MemWaitCycles_ME
);

  me_state_e             state_q, state_d;
  me_reg_t               me_q, me_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_op;
  logic                  misalign;
  logic                  dm_req_c;
  logic                  stall_c;
  logic [XLEN-1:0]       rd_fmt;

  assign mem_op = InstrVal_EX & (MemToReg_EX | MemWrite_EX);

`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;
  assign misalign    = mem_op & ~LoadB_EX & ~StoreB_EX & (Result_EX[1:0] != 2'b00);
  assign align_err_d = align_err_q | misalign;
  assign AlignErr_ME = align_err_q;
`else
  assign misalign = 1'b0;
`endif

  byte_lane_fmt u_fmt (
    .byte_sel   (Result_EX[1:0]),
    .store_byte (StoreB_EX),
    .load_byte  (LoadB_EX),
    .wr_dat     (WrDat_EX),
    .rd_dat     (DmRdDat),
    .byte_en_c  (DmByteEn),
    .wr_lane_c  (DmWrDat),
    .rd_fmt_c   (rd_fmt)
  );

  assign DmAddr = {Result_EX[XLEN-1:2], 2'b00};
  assign DmWe   = MemWrite_EX;

  // Request FSM; request and stall are forced low while reset is asserted
  always_comb begin
    state_d  = state_q;
    dm_req_c = 1'b0;
    stall_c  = 1'b0;
    case (state_q)
      ME_IDLE: begin
        if (mem_op && !misalign) begin
          dm_req_c = 1'b1;
          if (!DmAck) begin
            stall_c = 1'b1;
            state_d = ME_WAIT;
          end
        end
      end
      ME_WAIT: begin
        dm_req_c = 1'b1;
        if (DmAck) state_d = ME_IDLE;
        else       stall_c = 1'b1;
      end
      default: state_d = ME_IDLE;
    endcase
    if (!rst_n) begin
      dm_req_c = 1'b0;
      stall_c  = 1'b0;
    end
  end

  assign DmReq       = dm_req_c;
  assign MemStall_ME = stall_c;

  // ME register, deferred flush and wait-cycle counter
  always_comb begin
    me_d         = me_q;
    flush_pend_d = flush_pend_q;
    wait_cnt_d   = wait_cnt_q;
    if (stall_c) begin
      if (flush) flush_pend_d = 1'b1;
      if (wait_cnt_q != {WAIT_CNT_W{1'b1}}) wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
    end else begin
      flush_pend_d = 1'b0;
      if (flush || flush_pend_q || misalign) begin
        me_d = '0;
      end else begin
        me_d.result    = MemToReg_EX ? rd_fmt : Result_EX;
        me_d.wreg      = WriteReg_EX;
        me_d.reg_write = RegWrite_EX & InstrVal_EX;
        me_d.instr_val = InstrVal_EX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ME_IDLE;
      me_q         <= '0;
      flush_pend_q <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      me_q         <= me_d;
      flush_pend_q <= flush_pend_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) align_err_q <= 1'b0;
    else        align_err_q <= align_err_d;
  end
`endif

  assign ResultRdDat_ME   = me_q.result;
  assign WriteReg_ME      = me_q.wreg;
  assign RegWrite_ME      = me_q.reg_write;
  assign InstrVal_ME      = me_q.instr_val;
  assign MemWaitCycles_ME = wait_cnt_q;

endmodule
